// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (LSB first, one bit per clock).
// Define SERIAL_SUB_BIN_EN to add a borrow-in port (bin) for chaining wider subtractions.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted on a rising edge whenever the FSM is not in
  // SHIFT (i.e. IDLE or DONE); while busy=1 start is ignored. done is a
  // one-cycle pulse, and diff/borrow_out hold until the next completion.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_shift;
  logic             bin_init;

`ifdef SERIAL_SUB_BIN_EN
  assign bin_init = bin;
`else
  assign bin_init = 1'b0;
`endif

  // Single full-subtractor cell acting on the current LSBs.
  assign d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_nxt    = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin_init;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_shift;
        br_d  = br_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = res_shift;
          bout_d  = br_nxt;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign dbg_state  = state_q;

endmodule
